// File: rtl/bcd_serial_accumulator_pkg.sv
// Purpose: constants and state encoding shared by the BCD serial accumulator and its digit adder.
// Latency: none; this file holds declarations only.
// Backpressure: none; this file holds declarations only.
package bcd_pkg;

  localparam int          DIG_W   = 4;     // bits per BCD digit
  localparam logic [3:0]  BCD_MAX = 4'd9;  // largest legal BCD digit
  localparam logic [3:0]  BCD_CORR = 4'd6; // skips the six unused codes A..F

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_serial_accumulator_digit_add.sv
// Purpose: single-digit BCD adder; (a + b + c_in) with decimal correction.
// Latency: combinational, zero cycles.
// Backpressure: none; the output follows the inputs continuously.
//
// Ports: a, b - input digits (codes above 9 are still summed by the same rule)
//        c_in - carry in; s - corrected sum digit; c_out - decimal carry out
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] a,
  input  logic [DIG_W-1:0] b,
  input  logic             c_in,
  output logic [DIG_W-1:0] s,
  output logic             c_out
);

  logic [DIG_W:0] w_t;

  always_comb begin
    w_t   = {1'b0, a} + {1'b0, b} + {{DIG_W{1'b0}}, c_in};
    s     = w_t[DIG_W-1:0];
    c_out = 1'b0;
    // Past 9 the +6 correction wraps the low nibble modulo 16; this also
    // gives a defined result for illegal input codes (F+F+1 -> 5, carry).
    if (w_t > {1'b0, BCD_MAX}) begin
      s     = w_t[DIG_W-1:0] + BCD_CORR;
      c_out = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_accumulator.sv
// Purpose: multi-digit BCD adder, one digit pair per clock, LSD first, through one digit adder.
// Latency: done pulses exactly DIGITS cycles after the start-capturing edge.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted back-to-back.
//
// Ports: clk, rst_n (sync, active-low); start, A, B, C_in - request and operands (latched on accept)
//        busy - operation in progress; done - one-cycle result-valid pulse
//        S, C_out, err - sum, top carry, illegal-digit flag; held until next accept or reset
module bcd_serial_accumulator
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DIG_W*DIGITS-1:0] A,
  input  logic [DIG_W*DIGITS-1:0] B,
  input  logic                    C_in,
  output logic                    busy,
  output logic                    done,
  output logic [DIG_W*DIGITS-1:0] S,
  output logic                    C_out,
  output logic                    err
);

  localparam int              W        = DIG_W * DIGITS;
  localparam int              IDXW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_s;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic            r_busy;
  logic            r_done;
  logic            r_cout;
  logic            r_err;

  logic [DIG_W-1:0] w_a_dig;
  logic [DIG_W-1:0] w_b_dig;
  logic [DIG_W-1:0] w_sum_dig;
  logic             w_carry_nxt;
  logic             w_dig_bad;

  assign w_a_dig   = r_a[r_idx*DIG_W +: DIG_W];
  assign w_b_dig   = r_b[r_idx*DIG_W +: DIG_W];
  assign w_dig_bad = (w_a_dig > BCD_MAX) || (w_b_dig > BCD_MAX);

  bcd_digit_add u_digit_add (
    .a     (w_a_dig),
    .b     (w_b_dig),
    .c_in  (r_carry),
    .s     (w_sum_dig),
    .c_out (w_carry_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= C_in;
            r_idx   <= '0;
            r_s     <= '0;
            r_err   <= 1'b0;
            r_state <= ADD;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        ADD: begin
          r_s[r_idx*DIG_W +: DIG_W] <= w_sum_dig;
          r_carry <= w_carry_nxt;
          r_err   <= r_err | w_dig_bad;
          if (r_idx == LAST_IDX) begin
            // idx parks on the top digit; the next accept rewinds it.
            r_cout  <= w_carry_nxt;
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign S     = r_s;
  assign C_out = r_cout;
  assign err   = r_err;

endmodule

// File: tb/tb_bcd_serial_accumulator.sv
module tb_bcd_serial_accumulator;

  localparam int D = 4;
  localparam int W = 4 * D;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         err;
    int           done_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         C_in = 1'b0;
  logic         busy, done, C_out, err;
  logic [W-1:0] S;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  bcd_serial_accumulator #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .C_in(C_in),
    .busy(busy), .done(done), .S(S), .C_out(C_out), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: legal operands are plain decimal numbers added as integers;
  // operands with illegal codes fall back to the digit-by-digit rule.
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic cin);
    exp_t e;
    int   va, vb, sum, lim, t, c;
    logic [3:0] na, nb;
    e.err = 1'b0;
    for (int i = 0; i < D; i++)
      if (a[i*4 +: 4] > 9 || b[i*4 +: 4] > 9) e.err = 1'b1;
    e.s = '0;
    if (!e.err) begin
      va = 0; vb = 0; lim = 1;
      for (int i = 0; i < D; i++) begin
        va += int'(a[i*4 +: 4]) * lim;
        vb += int'(b[i*4 +: 4]) * lim;
        lim *= 10;
      end
      sum = va + vb + int'(cin);
      e.cout = (sum >= lim);
      sum = sum % lim;
      for (int i = 0; i < D; i++) begin
        e.s[i*4 +: 4] = 4'(sum % 10);
        sum = sum / 10;
      end
    end else begin
      c = int'(cin);
      for (int i = 0; i < D; i++) begin
        na = a[i*4 +: 4];
        nb = b[i*4 +: 4];
        t  = int'(na) + int'(nb) + c;
        if (t > 9) begin
          e.s[i*4 +: 4] = 4'((t + 6) % 16);
          c = 1;
        end else begin
          e.s[i*4 +: 4] = 4'(t);
          c = 0;
        end
      end
      e.cout = c[0];
    end
    e.done_cyc = 0;
    return e;
  endfunction

  // Call with inputs changed away from the rising edge; returns just after E0.
  task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic cin);
    exp_t e;
    start = 1'b1; A = a; B = b; C_in = cin;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = $urandom; B = $urandom; C_in = $urandom;
    e = model(a, b, cin);
    e.done_cyc = cyc + D;
    sb.push_back(e);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("done_latency", 32'(cyc), 32'(e.done_cyc));
        check("S", 32'(S), 32'(e.s));
        check("C_out", 32'(C_out), 32'(e.cout));
        check("err", 32'(err), 32'(e.err));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  function automatic logic [W-1:0] rand_operand(bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < D; i++)
      v[i*4 +: 4] = allow_bad ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_S", 32'(S), 32'd0);
    check("rst_C_out", 32'(C_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases 1..3 and 5.
    @(negedge clk); issue(16'h1234, 16'h5678, 1'b0);
    repeat (D + 2) @(negedge clk);
    issue(16'h9999, 16'h0001, 1'b0);
    repeat (D + 2) @(negedge clk);
    issue(16'h9999, 16'h9999, 1'b1);
    repeat (D + 2) @(negedge clk);
    issue(16'h000F, 16'h0001, 1'b0);
    repeat (D + 2) @(negedge clk);

    // Start during ADD is ignored; start in the done cycle is accepted.
    issue(16'h1234, 16'h5678, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; A = 16'h9999; B = 16'h9999; C_in = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("busy_ignores_start", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    check("done_cycle_before_b2b", 32'(done), 32'd1);
    issue(16'h0005, 16'h0005, 1'b0);
    check("done_drops_on_accept", 32'(done), 32'd0);
    check("S_cleared_on_accept", 32'(S), 32'd0);
    repeat (D + 2) @(negedge clk);

    // Reset mid-operation aborts with no done.
    issue(16'h1234, 16'h5678, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_S", 32'(S), 32'd0);
    check("abort_C_out", 32'(C_out), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (D + 2) @(negedge clk);
    issue(16'h1234, 16'h5678, 1'b0);
    repeat (D + 2) @(negedge clk);

    // Randomized operations, sometimes back-to-back, sometimes illegal digits.
    for (int n = 0; n < 40; n++) begin
      issue(rand_operand($urandom_range(0, 3) == 0),
            rand_operand($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)));
      repeat (D + 1 + $urandom_range(0, 2)) @(negedge clk);
    end

    // Drain: every expected result must have been seen.
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_serial_accumulator.md
Name: bcd_serial_accumulator

Overview:
- Multi-digit BCD adder that processes one digit pair per clock, least-significant digit first.
- Latches two DIGITS-wide packed BCD operands on a start pulse and walks them through a single-digit BCD add stage, rippling the decimal carry in a register.
- Raises done when the full sum is ready.
- Sits upstream and downstream of the single-digit BCD adder stage: it feeds that stage digit pairs and collects its sum and carry, so wide decimal addition costs one digit adder instead of DIGITS.

Parameters:
- DIGITS, 4, number of BCD digits per operand (>=1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request pulse; sampled every rising edge.
- A  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0].
- B  input  4*DIGITS  operand B, packed BCD.
- C_in  input  1  decimal carry into digit 0.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: S, C_out and err are final.
- S  output  4*DIGITS  packed BCD sum.
- C_out  output  1  decimal carry out of the top digit.
- err  output  1  some operand digit was >9 in the completed operation.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; busy=0, done=0, S=0, C_out=0, err=0; digit index=0. An operation in progress is aborted and no done is produced.
- States: IDLE, ADD, DONE.
  - IDLE: start=1 -> accept.
  - DONE: start=1 -> accept (back-to-back); otherwise -> IDLE.
  - ADD: start is ignored.
- Accept, at the capturing edge E0:
  - latch A and B into internal operand registers; later input changes have no effect;
  - carry register <= C_in, idx <= 0, S <= 0, err <= 0;
  - state <= ADD, busy <= 1.
- ADD, edges E1..E_DIGITS: each edge processes digit idx.
  - t = a[idx] + b[idx] + carry, 5-bit unsigned.
  - If t > 9: digit = (t + 6) mod 16, carry_next = 1. Else: digit = t[3:0], carry_next = 0.
  - S[idx] <= digit, carry <= carry_next, idx <= idx + 1.
  - err <= err OR (a[idx] > 9) OR (b[idx] > 9).
  - Digits above idx stay 0.
- At edge E_DIGITS:
  - C_out <= carry_next, state <= DONE, busy <= 0, done <= 1.
  - done is therefore visible exactly DIGITS cycles after the start-capturing edge.
- At edge E_DIGITS+1: done <= 0.
  - S, C_out and err hold until the next accept or reset.
- Invalid digits: the result is still computed with the rule above; for example a=F, b=F, c=1 gives t=31 -> digit 5, carry 1. err flags the condition; there is no stall and no saturation.
- idx width is clog2(DIGITS), minimum 1. idx never exceeds DIGITS-1 and does not wrap within an operation.
- DIGITS=1: ADD lasts exactly one cycle.
- Simultaneous events:
  - rst_n=0 and start=1 on the same edge: reset wins.
  - start=1 in DONE: done drops, the new accept occurs, and S is cleared on that same edge.
- C_out is updated only at completion. C_out from the previous operation remains visible during ADD until overwritten.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_MAX = 9 and BCD_CORR = 6;
  - state encoding IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2;
  - a digit-width constant of 4.
- One combinational sub-module, bcd_digit_add (4-bit a, 4-bit b, c_in -> 4-bit s, c_out), implements the per-digit rule. It is instantiated once.
- The sequencer (FSM, idx counter, operand/carry/result registers) stays in the top module.

Test Plan:
1. DIGITS=4, A=0x1234, B=0x5678, C_in=0, start pulse -> busy for 4 cycles; done exactly 4 cycles after the start edge; S=0x6912, C_out=0, err=0.
2. A=0x9999, B=0x0001, C_in=0 -> S=0x0000, C_out=1, err=0; the carry ripples through all 4 digits.
3. A=0x9999, B=0x9999, C_in=1 -> S=0x9999, C_out=1, err=0.
4. start re-pulsed at E2 with different A and B -> ignored, and case-1 result unchanged; then start asserted in the done cycle with A=0x0005, B=0x0005 -> accepted; done 4 cycles later with S=0x0010, C_out=0.
5. A=0x000F, B=0x0001, C_in=0 -> S=0x0016, C_out=0, err=1.
6. Operation as case 1 with rst_n=0 at E2 -> busy=0, S=0, C_out=0, err=0, no done pulse; a following start with case-1 operands produces the correct result.
